jump_unit_ras: RTL and testbench
================================

Name: jump_unit_ras

Overview:
- Parametrised, pipelined jump-target unit for the execute stage.
- Computes PC-relative (displacement) and register-indirect (Rs+imm) jump targets into a one-cycle output register, with signed-overflow detection.
- Adds a return-address stack (RAS): link jumps push the return address; return jumps are checked against the predicted top-of-stack.
- Supplies the fetch stage with the prediction and the PC-redirect logic with a mispredict flag.

Parameters:
- WIDTH, 16, datapath/PC width in bits
- DISP_W, 11, displacement field width; sign-extended to WIDTH
- RAS_DEPTH, 8, RAS entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all state; request ignored this cycle
- flush  in  1  drop this cycle's request; clear output valids
- jump_i  in  1  register-indirect jump request (Rs+imm)
- jump_d  in  1  displacement jump request (PC+2+disp)
- link  in  1  request also writes the link register (push return address)
- ret  in  1  request is a subroutine return (pop and check)
- disp  in  DISP_W  displacement field
- imm_ext  in  WIDTH  extended immediate
- rs  in  WIDTH  Rs operand
- pc_plus_two  in  WIDTH  PC of this instruction + 2
- target  out  WIDTH  registered jump target
- target_valid  out  1  registered; target holds a live result
- err  out  1  registered; overflow or illegal request
- mispredict  out  1  registered; return target differed from prediction
- pred_target  out  WIDTH  combinational RAS top (0 when empty)
- pred_valid  out  1  combinational; RAS non-empty
- ras_count  out  $clog2(RAS_DEPTH+1)  current occupancy

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous and active-high. On reset: target=0, target_valid=0, err=0, mispredict=0, ras_count=0, RAS pointer=0. Reset mid-operation discards the in-flight result and the stack contents.
- Request: req = (jump_i|jump_d) & ~stall & ~flush.
- Operands: a = jump_d ? pc_plus_two : rs; b = jump_d ? sext(disp) : imm_ext.
- Sum: a+b modulo 2^WIDTH.
- Overflow: ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
- Illegal request: jump_i & jump_d both set. jump_d takes priority and err=1.
- Latency: 1 cycle. On the edge where req=1: target<=sum, target_valid<=1, err<=ovf|illegal.
- Idle cycle: when ~stall and req=0, target_valid<=0, err<=0 and mispredict<=0. target holds its last value.
- stall=1: every register, including the RAS, holds. stall has priority over flush.
- flush=1 (no stall): target_valid, err and mispredict clear. No RAS change.
- ret check: on req & ret, mispredict<=(~pred_valid) | (sum != pred_target). The comparison uses the top-of-stack before this cycle's update.
- Pop: req & ret & ~link, when non-empty → count-1.
- Pop on empty: no change; mispredict=1.
- Push: req & link & ~ret → entry[ptr+1]<=pc_plus_two; count=min(count+1, RAS_DEPTH).
- Push when full: the pointer wraps and overwrites the oldest entry; count stays RAS_DEPTH.
- link & ret together: replace top with pc_plus_two; count unchanged. If empty, behaves as a push (count=1).
- Pointer arithmetic: modulo RAS_DEPTH.
- Outputs: pred_target/pred_valid always reflect the current top, never the post-edge value.

Decomposition:
- Package jump_pkg: default WIDTH/DISP_W/RAS_DEPTH, RAS op encoding (NOP, PUSH, POP, REPLACE), count width function.
- Sub-module ras_stack (op, push_data → top, valid, count) holds the circular buffer and pointer.
- The adder and registers stay in jump_unit_ras; the existing cla_16b may be instantiated when WIDTH=16.

Test Plan:
- jump_d, pc_plus_two=0x0100, disp=0x7FE (-2) → next cycle target=0x00FE, target_valid=1, err=0.
- jump_i, rs=0x7FFF, imm_ext=0x0001 → target=0x8000, err=1. Then an idle cycle → target_valid=0, err=0.
- jump_d|link at pc_plus_two=0x0200, then jump_i|ret with rs=0x0200, imm=0 → pred_target=0x0200, mispredict=0, ras_count back to 0.
- RAS_DEPTH=8: 9 link pushes (return addresses 0x10..0x90 step 0x10) → count=8, top=0x90. 8 pops yield 0x90 down to 0x20, then pred_valid=0.
- ret on empty RAS → mispredict=1, count stays 0.
- Stall and reset: stall=1 with a request → outputs and count unchanged. Assert rst asynchronously mid-cycle → all outputs 0 immediately.

Source files
------------

// File: rtl/jump_unit_ras_pkg.sv
// Shared defaults, RAS operation encoding and sizing helper for the jump unit.
package jump_pkg;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DISP_W    = 11;
  localparam int DEF_RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    RAS_NOP     = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_REPLACE = 2'd3
  } ras_op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/jump_unit_ras_if.sv
// Request/response bundle between execute control and the jump unit.
interface jump_unit_ras_if
  import jump_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DISP_W    = DEF_DISP_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
);
  localparam int CW = cnt_w(RAS_DEPTH);

  logic              stall, flush;
  logic              jump_i, jump_d, link, ret;
  logic [DISP_W-1:0] disp;
  logic [WIDTH-1:0]  imm_ext, rs, pc_plus_two;
  logic [WIDTH-1:0]  target;
  logic              target_valid, err, mispredict;
  logic [WIDTH-1:0]  pred_target;
  logic              pred_valid;
  logic [CW-1:0]     ras_count;

  modport master (
    output stall, flush, jump_i, jump_d, link, ret, disp, imm_ext, rs, pc_plus_two,
    input  target, target_valid, err, mispredict, pred_target, pred_valid, ras_count
  );
  modport slave (
    input  stall, flush, jump_i, jump_d, link, ret, disp, imm_ext, rs, pc_plus_two,
    output target, target_valid, err, mispredict, pred_target, pred_valid, ras_count
  );
endinterface

// File: rtl/jump_unit_ras_stack.sv
// Circular return-address stack; ptr_q addresses the current top, a full push
// overwrites the oldest entry.
module ras_stack
  import jump_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int CW        = cnt_w(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  ras_op_e          op,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             valid,
  output logic [CW-1:0]    count
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [RAS_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]                   ptr_q, ptr_d;
  logic [CW-1:0]                   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    case (op)
      RAS_PUSH: begin
        ptr_d        = ptr_q + PW'(1);
        mem_d[ptr_d] = push_data;
        if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      end
      RAS_POP: begin
        if (cnt_q != '0) begin
          ptr_d = ptr_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end
      RAS_REPLACE: begin
        // replacing on an empty stack degenerates into a push
        if (cnt_q == '0) begin
          ptr_d        = ptr_q + PW'(1);
          mem_d[ptr_d] = push_data;
          cnt_d        = CW'(1);
        end else begin
          mem_d[ptr_q] = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid = (cnt_q != '0);
  assign top   = valid ? mem_q[ptr_q] : '0;
  assign count = cnt_q;
endmodule

// File: rtl/jump_unit_ras.sv
// Execute-stage jump target unit: one-cycle registered target with overflow
// detection, plus a return-address stack for return prediction.
module jump_unit_ras
  import jump_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DISP_W    = DEF_DISP_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  jump_unit_ras_if.slave  bus
);
  localparam int CW = cnt_w(RAS_DEPTH);

  logic             req, illegal, ovf;
  logic [WIDTH-1:0] a, b, sum, pred_top;
  logic             pred_vld;
  ras_op_e          op;

  logic [WIDTH-1:0] target_q, target_d;
  logic             tv_q, tv_d, err_q, err_d, mis_q, mis_d;

  assign req     = (bus.jump_i | bus.jump_d) & ~bus.stall & ~bus.flush;
  assign illegal = bus.jump_i & bus.jump_d;
  assign a       = bus.jump_d ? bus.pc_plus_two : bus.rs;
  assign b       = bus.jump_d ? {{(WIDTH-DISP_W){bus.disp[DISP_W-1]}}, bus.disp} : bus.imm_ext;
  assign sum     = a + b;
  assign ovf     = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    op = RAS_NOP;
    if (req) begin
      if (bus.link && bus.ret) op = RAS_REPLACE;
      else if (bus.link)       op = RAS_PUSH;
      else if (bus.ret)        op = RAS_POP;
    end
  end

  ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH), .CW(CW)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .push_data (bus.pc_plus_two),
    .top       (pred_top),
    .valid     (pred_vld),
    .count     (bus.ras_count)
  );

  always_comb begin
    target_d = target_q;
    tv_d     = tv_q;
    err_d    = err_q;
    mis_d    = mis_q;
    if (!bus.stall) begin
      tv_d  = 1'b0;
      err_d = 1'b0;
      mis_d = 1'b0;
      if (req) begin
        target_d = sum;
        tv_d     = 1'b1;
        err_d    = ovf | illegal;
        // check against the top as it stood before this cycle's stack update
        mis_d    = bus.ret & (~pred_vld | (sum != pred_top));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      tv_q     <= 1'b0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      tv_q     <= tv_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.target       = target_q;
  assign bus.target_valid = tv_q;
  assign bus.err          = err_q;
  assign bus.mispredict   = mis_q;
  assign bus.pred_target  = pred_top;
  assign bus.pred_valid   = pred_vld;
endmodule

// File: tb/tb_jump_unit_ras.sv
// Directed scoreboard bench for jump_unit_ras: stimulus pushes the expected
// post-edge state, a monitor pops and compares after every rising edge.
module tb_jump_unit_ras;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jump_unit_ras_if #(.WIDTH(16), .DISP_W(11), .RAS_DEPTH(8)) bus ();
  jump_unit_ras #(.WIDTH(16), .DISP_W(11), .RAS_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    logic [15:0] tgt;
    logic        tv, err, mis;
    logic [15:0] pt;
    logic        pv;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.nm, ".target"},       32'(bus.target),       32'(e.tgt));
    chk({e.nm, ".target_valid"}, 32'(bus.target_valid), 32'(e.tv));
    chk({e.nm, ".err"},          32'(bus.err),          32'(e.err));
    chk({e.nm, ".mispredict"},   32'(bus.mispredict),   32'(e.mis));
    chk({e.nm, ".pred_target"},  32'(bus.pred_target),  32'(e.pt));
    chk({e.nm, ".pred_valid"},   32'(bus.pred_valid),   32'(e.pv));
    chk({e.nm, ".ras_count"},    32'(bus.ras_count),    32'(e.cnt));
  endtask

  // monitor: every registered result is visible just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) chk_all(sb.pop_front());
    end
  end

  task automatic idle();
    bus.stall = 0; bus.flush = 0;
    bus.jump_i = 0; bus.jump_d = 0; bus.link = 0; bus.ret = 0;
    bus.disp = '0; bus.imm_ext = '0; bus.rs = '0; bus.pc_plus_two = '0;
  endtask

  task automatic go(input string nm, input logic [15:0] tgt, input logic tv, input logic err,
                    input logic mis, input logic [15:0] pt, input logic pv, input int cnt);
    exp_t e;
    e.nm = nm; e.tgt = tgt; e.tv = tv; e.err = err; e.mis = mis;
    e.pt = pt; e.pv = pv; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    idle();
  endtask

  initial begin
    exp_t r;
    idle();
    #3;
    r.nm = "reset"; r.tgt = 0; r.tv = 0; r.err = 0; r.mis = 0; r.pt = 0; r.pv = 0; r.cnt = 0;
    chk_all(r);
    @(negedge clk);
    rst = 0;

    // displacement jump, negative displacement
    bus.jump_d = 1; bus.pc_plus_two = 16'h0100; bus.disp = 11'h7FE;
    go("disp_neg", 16'h00FE, 1, 0, 0, 16'h0000, 0, 0);
    // indirect jump with positive overflow
    bus.jump_i = 1; bus.rs = 16'h7FFF; bus.imm_ext = 16'h0001;
    go("ind_ovf", 16'h8000, 1, 1, 0, 16'h0000, 0, 0);
    go("idle", 16'h8000, 0, 0, 0, 16'h0000, 0, 0);

    // call then matching return
    bus.jump_d = 1; bus.link = 1; bus.pc_plus_two = 16'h0200; bus.disp = 11'h000;
    go("call", 16'h0200, 1, 0, 0, 16'h0200, 1, 1);
    bus.jump_i = 1; bus.ret = 1; bus.rs = 16'h0200; bus.imm_ext = 16'h0000; bus.pc_plus_two = 16'h0300;
    go("ret_hit", 16'h0200, 1, 0, 0, 16'h0000, 0, 0);

    // return on empty stack
    bus.jump_i = 1; bus.ret = 1; bus.rs = 16'h0040;
    go("ret_empty", 16'h0040, 1, 0, 1, 16'h0000, 0, 0);

    // nine pushes into an eight-deep stack: oldest entry overwritten
    for (int k = 1; k <= 9; k++) begin
      bus.jump_d = 1; bus.link = 1; bus.pc_plus_two = 16'(k * 16'h10); bus.disp = 11'h004;
      go($sformatf("push%0d", k), 16'(k * 16'h10 + 4), 1, 0, 0, 16'(k * 16'h10), 1,
         (k < 8) ? k : 8);
    end
    for (int i = 0; i < 8; i++) begin
      bus.jump_i = 1; bus.ret = 1; bus.rs = 16'(16'h90 - i * 16'h10); bus.imm_ext = 16'h0000;
      go($sformatf("pop%0d", i), 16'(16'h90 - i * 16'h10), 1, 0, 0,
         (i < 7) ? 16'(16'h80 - i * 16'h10) : 16'h0000, (i < 7), 7 - i);
    end

    // link+ret replaces the top; the return itself mispredicts
    bus.jump_d = 1; bus.link = 1; bus.pc_plus_two = 16'h0500; bus.disp = 11'h000;
    go("push500", 16'h0500, 1, 0, 0, 16'h0500, 1, 1);
    bus.jump_d = 1; bus.link = 1; bus.ret = 1; bus.pc_plus_two = 16'h0600; bus.disp = 11'h000;
    go("replace", 16'h0600, 1, 0, 1, 16'h0600, 1, 1);
    bus.flush = 1; bus.jump_d = 1; bus.link = 1; bus.pc_plus_two = 16'h0700;
    go("flush", 16'h0600, 0, 0, 0, 16'h0600, 1, 1);

    // stall holds everything, including against flush
    bus.jump_i = 1; bus.rs = 16'h1234; bus.imm_ext = 16'h0001;
    go("live", 16'h1235, 1, 0, 0, 16'h0600, 1, 1);
    bus.stall = 1; bus.jump_d = 1; bus.link = 1; bus.pc_plus_two = 16'h0700;
    go("stall", 16'h1235, 1, 0, 0, 16'h0600, 1, 1);
    bus.stall = 1; bus.flush = 1; bus.jump_i = 1; bus.ret = 1;
    go("stall_flush", 16'h1235, 1, 0, 0, 16'h0600, 1, 1);

    // both request kinds: displacement wins, flagged as error
    bus.jump_i = 1; bus.jump_d = 1; bus.pc_plus_two = 16'h0100; bus.disp = 11'h002; bus.rs = 16'hFFFF;
    go("illegal", 16'h0102, 1, 1, 0, 16'h0600, 1, 1);
    // negative overflow
    bus.jump_i = 1; bus.rs = 16'h8000; bus.imm_ext = 16'hFFFF;
    go("neg_ovf", 16'h7FFF, 1, 1, 0, 16'h0600, 1, 1);
    bus.jump_d = 1; bus.pc_plus_two = 16'h0300; bus.disp = 11'h001;
    go("pre_rst", 16'h0301, 1, 0, 0, 16'h0600, 1, 1);

    // asynchronous reset in mid-cycle
    #2;
    rst = 1;
    #1;
    r.nm = "async_rst"; r.tgt = 0; r.tv = 0; r.err = 0; r.mis = 0; r.pt = 0; r.pv = 0; r.cnt = 0;
    chk_all(r);
    @(negedge clk);
    rst = 0;
    bus.jump_d = 1; bus.link = 1; bus.pc_plus_two = 16'h0800; bus.disp = 11'h000;
    go("post_rst", 16'h0800, 1, 0, 0, 16'h0800, 1, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
